// File: rtl/id_ex_pipe_reg_if.sv
// ID/EX pipeline register bus: ID-side control/operands in, EX-side registered copies out.
// The master drives stall/flush/id_*, and the slave (the pipeline register) drives ex_*.
interface id_ex_pipe_reg_if #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5
);
  logic                     stall;
  logic                     flush;
  logic                     id_valid;
  logic [1:0]               id_alu_type;
  logic [5:0]               id_func;
  logic                     id_reg_write;
  logic                     id_mem_read;
  logic                     id_mem_write;
  logic                     id_mem_to_reg;
  logic                     id_alu_src;
  logic                     id_reg_dst;
  logic signed [DATA_W-1:0] id_rs_data;
  logic signed [DATA_W-1:0] id_rt_data;
  logic signed [DATA_W-1:0] id_imm;
  logic [REG_W-1:0]         id_rs;
  logic [REG_W-1:0]         id_rt;
  logic [REG_W-1:0]         id_rd;

  logic                     ex_valid;
  logic [1:0]               ex_alu_type;
  logic [5:0]               ex_func;
  logic                     ex_reg_write;
  logic                     ex_mem_read;
  logic                     ex_mem_write;
  logic                     ex_mem_to_reg;
  logic                     ex_alu_src;
  logic                     ex_reg_dst;
  logic signed [DATA_W-1:0] ex_rs_data;
  logic signed [DATA_W-1:0] ex_rt_data;
  logic signed [DATA_W-1:0] ex_imm;
  logic [REG_W-1:0]         ex_rs;
  logic [REG_W-1:0]         ex_rt;
  logic [REG_W-1:0]         ex_rd;
  logic [REG_W-1:0]         ex_dest;

  modport master (
    output stall, flush, id_valid, id_alu_type, id_func, id_reg_write, id_mem_read,
           id_mem_write, id_mem_to_reg, id_alu_src, id_reg_dst, id_rs_data, id_rt_data,
           id_imm, id_rs, id_rt, id_rd,
    input  ex_valid, ex_alu_type, ex_func, ex_reg_write, ex_mem_read, ex_mem_write,
           ex_mem_to_reg, ex_alu_src, ex_reg_dst, ex_rs_data, ex_rt_data, ex_imm,
           ex_rs, ex_rt, ex_rd, ex_dest
  );

  modport slave (
    input  stall, flush, id_valid, id_alu_type, id_func, id_reg_write, id_mem_read,
           id_mem_write, id_mem_to_reg, id_alu_src, id_reg_dst, id_rs_data, id_rt_data,
           id_imm, id_rs, id_rt, id_rd,
    output ex_valid, ex_alu_type, ex_func, ex_reg_write, ex_mem_read, ex_mem_write,
           ex_mem_to_reg, ex_alu_src, ex_reg_dst, ex_rs_data, ex_rt_data, ex_imm,
           ex_rs, ex_rt, ex_rd, ex_dest
  );
endinterface

// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register of the 5-stage MIPS pipeline with stall hold and bubble insertion.
// Optional macro ID_EX_PERF_CNT_EN adds saturating stall_cnt / flush_cnt outputs.
module id_ex_pipe_reg #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5
) (
  input  logic             clk,
  input  logic             rst,
  id_ex_pipe_reg_if.slave  bus
`ifdef ID_EX_PERF_CNT_EN
  ,
  output logic [15:0]      stall_cnt,
  output logic [15:0]      flush_cnt
`endif
);

`ifdef ID_EX_PERF_CNT_EN
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction
`endif

  logic                     vld_p1;
  logic [1:0]               alu_type_p1;
  logic [5:0]               func_p1;
  logic                     reg_write_p1;
  logic                     mem_read_p1;
  logic                     mem_write_p1;
  logic                     mem_to_reg_p1;
  logic                     alu_src_p1;
  logic                     reg_dst_p1;
  logic signed [DATA_W-1:0] rs_data_p1;
  logic signed [DATA_W-1:0] rt_data_p1;
  logic signed [DATA_W-1:0] imm_p1;
  logic [REG_W-1:0]         rs_p1;
  logic [REG_W-1:0]         rt_p1;
  logic [REG_W-1:0]         rd_p1;
  logic [REG_W-1:0]         dest_p1;

  // A bubble clears every field so nothing downstream can commit; stall only holds.
  logic clr_p0;
  logic ld_p0;
  assign clr_p0 = rst | bus.flush | (~bus.stall & ~bus.id_valid);
  assign ld_p0  = ~bus.stall;

  // ID -> EX stage boundary
  always_ff @(posedge clk) begin
    if (clr_p0) begin
      vld_p1        <= 1'b0;
      alu_type_p1   <= 2'b00;
      func_p1       <= 6'd0;
      reg_write_p1  <= 1'b0;
      mem_read_p1   <= 1'b0;
      mem_write_p1  <= 1'b0;
      mem_to_reg_p1 <= 1'b0;
      alu_src_p1    <= 1'b0;
      reg_dst_p1    <= 1'b0;
      rs_data_p1    <= '0;
      rt_data_p1    <= '0;
      imm_p1        <= '0;
      rs_p1         <= '0;
      rt_p1         <= '0;
      rd_p1         <= '0;
      dest_p1       <= '0;
    end else if (ld_p0) begin
      vld_p1        <= 1'b1;
      alu_type_p1   <= bus.id_alu_type;
      func_p1       <= bus.id_func;
      reg_write_p1  <= bus.id_reg_write;
      mem_read_p1   <= bus.id_mem_read;
      mem_write_p1  <= bus.id_mem_write;
      mem_to_reg_p1 <= bus.id_mem_to_reg;
      alu_src_p1    <= bus.id_alu_src;
      reg_dst_p1    <= bus.id_reg_dst;
      rs_data_p1    <= bus.id_rs_data;
      rt_data_p1    <= bus.id_rt_data;
      imm_p1        <= bus.id_imm;
      rs_p1         <= bus.id_rs;
      rt_p1         <= bus.id_rt;
      rd_p1         <= bus.id_rd;
      dest_p1       <= bus.id_reg_dst ? bus.id_rd : bus.id_rt;
    end
  end

  assign bus.ex_valid      = vld_p1;
  assign bus.ex_alu_type   = alu_type_p1;
  assign bus.ex_func       = func_p1;
  assign bus.ex_reg_write  = reg_write_p1;
  assign bus.ex_mem_read   = mem_read_p1;
  assign bus.ex_mem_write  = mem_write_p1;
  assign bus.ex_mem_to_reg = mem_to_reg_p1;
  assign bus.ex_alu_src    = alu_src_p1;
  assign bus.ex_reg_dst    = reg_dst_p1;
  assign bus.ex_rs_data    = rs_data_p1;
  assign bus.ex_rt_data    = rt_data_p1;
  assign bus.ex_imm        = imm_p1;
  assign bus.ex_rs         = rs_p1;
  assign bus.ex_rt         = rt_p1;
  assign bus.ex_rd         = rd_p1;
  assign bus.ex_dest       = dest_p1;

`ifdef ID_EX_PERF_CNT_EN
  // A stall overridden by a flush is not counted as a stall.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= 16'd0;
      flush_cnt <= 16'd0;
    end else begin
      if (bus.stall && !bus.flush) stall_cnt <= sat_inc(stall_cnt);
      if (bus.flush)               flush_cnt <= sat_inc(flush_cnt);
    end
  end
`endif

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Table-driven bench for id_ex_pipe_reg: vectors of {rst, stall, flush, id bundle, expected ex bundle}.
// Define ID_EX_PERF_CNT_EN to also exercise the performance counters.
module tb_id_ex_pipe_reg;

  typedef struct packed {
    logic        valid;
    logic [1:0]  alu_type;
    logic [5:0]  func;
    logic [5:0]  ctrl;      // {reg_write, mem_read, mem_write, mem_to_reg, alu_src, reg_dst}
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [31:0] imm;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
  } in_t;

  typedef struct packed {
    logic        valid;
    logic [1:0]  alu_type;
    logic [5:0]  func;
    logic [5:0]  ctrl;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [31:0] imm;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  dest;
  } exp_t;

  typedef struct packed {
    logic rst;
    logic stall;
    logic flush;
    in_t  in;
    exp_t exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  id_ex_pipe_reg_if #(.DATA_W(32), .REG_W(5)) bus ();

`ifdef ID_EX_PERF_CNT_EN
  logic [15:0] stall_cnt;
  logic [15:0] flush_cnt;
  id_ex_pipe_reg #(.DATA_W(32), .REG_W(5)) dut (
    .clk(clk), .rst(rst), .bus(bus.slave), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );
`else
  id_ex_pipe_reg #(.DATA_W(32), .REG_W(5)) dut (
    .clk(clk), .rst(rst), .bus(bus.slave)
  );
`endif

  in_t  A, B, C, D, E, F;
  exp_t EA, EB, ED, EE, EF, ZE;
  vec_t vecs[$];

  function automatic vec_t mk(input logic r, input logic s, input logic f, input in_t i, input exp_t e);
    vec_t v;
    v.rst = r; v.stall = s; v.flush = f; v.in = i; v.exp = e;
    return v;
  endfunction

  task automatic drive(input logic r, input logic s, input logic f, input in_t i);
    rst               = r;
    bus.stall         = s;
    bus.flush         = f;
    bus.id_valid      = i.valid;
    bus.id_alu_type   = i.alu_type;
    bus.id_func       = i.func;
    {bus.id_reg_write, bus.id_mem_read, bus.id_mem_write,
     bus.id_mem_to_reg, bus.id_alu_src, bus.id_reg_dst} = i.ctrl;
    bus.id_rs_data    = i.rs_data;
    bus.id_rt_data    = i.rt_data;
    bus.id_imm        = i.imm;
    bus.id_rs         = i.rs;
    bus.id_rt         = i.rt;
    bus.id_rd         = i.rd;
  endtask

  function automatic exp_t grab();
    return {bus.ex_valid, bus.ex_alu_type, bus.ex_func,
            bus.ex_reg_write, bus.ex_mem_read, bus.ex_mem_write,
            bus.ex_mem_to_reg, bus.ex_alu_src, bus.ex_reg_dst,
            bus.ex_rs_data, bus.ex_rt_data, bus.ex_imm,
            bus.ex_rs, bus.ex_rt, bus.ex_rd, bus.ex_dest};
  endfunction

  task automatic check_ex(input string name, input exp_t want);
    exp_t got;
    got = grab();
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, got, want);
    end
  endtask

  task automatic check16(input string name, input logic [15:0] got, input logic [15:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, got, want);
    end
  endtask

  task automatic step(input logic r, input logic s, input logic f, input in_t i);
    drive(r, s, f, i);
    @(posedge clk);
    #1;
  endtask

  initial begin
    // R-type sub, rd=5, reg_dst=1
    A  = {1'b1, 2'b10, 6'b100010, 6'b100001, 32'h1111_0001, 32'h2222_0002, 32'hFFFF_FFF0, 5'd1, 5'd2, 5'd5};
    EA = {1'b1, 2'b10, 6'b100010, 6'b100001, 32'h1111_0001, 32'h2222_0002, 32'hFFFF_FFF0, 5'd1, 5'd2, 5'd5, 5'd5};
    // lw, dest = rt
    B  = {1'b1, 2'b00, 6'b000000, 6'b110110, 32'h0000_1000, 32'hDEAD_BEEF, 32'h0000_0004, 5'd3, 5'd7, 5'd9};
    EB = {1'b1, 2'b00, 6'b000000, 6'b110110, 32'h0000_1000, 32'hDEAD_BEEF, 32'h0000_0004, 5'd3, 5'd7, 5'd9, 5'd7};
    // invalid slot carrying write enables
    C  = {1'b0, 2'b00, 6'b111000, 6'b101010, 32'hCAFE_0000, 32'h0BAD_F00D, 32'h0000_0010, 5'd4, 5'd6, 5'd8};
    // beq with extreme operands
    D  = {1'b1, 2'b01, 6'b101010, 6'b000000, 32'h8000_0000, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 5'd31, 5'd30, 5'd29};
    ED = {1'b1, 2'b01, 6'b101010, 6'b000000, 32'h8000_0000, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 5'd31, 5'd30, 5'd29, 5'd30};
    // andi
    E  = {1'b1, 2'b11, 6'b111111, 6'b100010, 32'h0000_00FF, 32'h1234_5678, 32'h0000_0F0F, 5'd11, 5'd12, 5'd4};
    EE = {1'b1, 2'b11, 6'b111111, 6'b100010, 32'h0000_00FF, 32'h1234_5678, 32'h0000_0F0F, 5'd11, 5'd12, 5'd4, 5'd12};
    // every control bit set
    F  = {1'b1, 2'b10, 6'b100000, 6'b111111, 32'hA5A5_A5A5, 32'h5A5A_5A5A, 32'h0000_0000, 5'd8, 5'd9, 5'd10};
    EF = {1'b1, 2'b10, 6'b100000, 6'b111111, 32'hA5A5_A5A5, 32'h5A5A_5A5A, 32'h0000_0000, 5'd8, 5'd9, 5'd10, 5'd10};
    ZE = '0;

    vecs.push_back(mk(1, 0, 0, A, ZE));   // reset, cycle 1
    vecs.push_back(mk(1, 0, 0, D, ZE));   // reset, cycle 2
    vecs.push_back(mk(0, 0, 0, A, EA));   // load R-type
    vecs.push_back(mk(0, 1, 0, B, EA));   // stall x3 while ID shows B
    vecs.push_back(mk(0, 1, 0, B, EA));
    vecs.push_back(mk(0, 1, 0, B, EA));
    vecs.push_back(mk(0, 0, 0, B, EB));   // release: B loaded
    vecs.push_back(mk(0, 0, 0, C, ZE));   // invalid ID -> bubble
    vecs.push_back(mk(0, 0, 0, D, ED));
    vecs.push_back(mk(0, 1, 1, F, ZE));   // flush beats stall
    vecs.push_back(mk(0, 0, 0, F, EF));
    vecs.push_back(mk(0, 0, 1, E, ZE));   // flush alone
    vecs.push_back(mk(0, 0, 0, E, EE));
    vecs.push_back(mk(1, 1, 0, A, ZE));   // reset mid-stall
    vecs.push_back(mk(0, 0, 0, A, EA));
    vecs.push_back(mk(1, 0, 1, B, ZE));   // reset mid-flush
    vecs.push_back(mk(0, 0, 0, D, ED));
    vecs.push_back(mk(0, 1, 0, A, ED));   // stall holds D
    vecs.push_back(mk(0, 0, 0, C, ZE));

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].rst, vecs[i].stall, vecs[i].flush, vecs[i].in);
      check_ex($sformatf("vec%0d", i), vecs[i].exp);
    end

    // Long stall with ID changing every cycle, then release.
    step(0, 0, 0, E);
    check_ex("long_stall_load", EE);
    for (int k = 0; k < 9; k++) begin
      step(0, 1, 0, (k % 3 == 0) ? A : (k % 3 == 1) ? B : D);
      check_ex($sformatf("long_stall_hold%0d", k), EE);
    end
    step(0, 0, 0, B);
    check_ex("long_stall_release", EB);

`ifdef ID_EX_PERF_CNT_EN
    step(1, 0, 0, C);
    check16("cnt_rst_stall", stall_cnt, 16'd0);
    check16("cnt_rst_flush", flush_cnt, 16'd0);
    for (int k = 0; k < 5; k++) step(0, 1, 0, A);
    for (int k = 0; k < 2; k++) step(0, 0, 1, A);
    step(0, 0, 0, A);
    check16("stall_cnt5", stall_cnt, 16'd5);
    check16("flush_cnt2", flush_cnt, 16'd2);
    for (int k = 0; k < 70000; k++) step(0, 1, 0, B);
    check16("stall_cnt_sat", stall_cnt, 16'hFFFF);
    check16("flush_cnt_keep", flush_cnt, 16'd2);
    step(1, 1, 1, B);
    check16("stall_cnt_clr", stall_cnt, 16'd0);
    check16("flush_cnt_clr", flush_cnt, 16'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
